// File: rtl/tt_arq_rx.sv
// Stop-and-wait ARQ receiver: takes two-beat frames (data byte, then its
// ones-complement check byte), answers with an ACK or NAK pulse and queues
// new, intact data bytes in a small circular FIFO for the consumer.
module tt_arq_rx #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ACK_PULSE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (ACK_PULSE > 1) ? $clog2(ACK_PULSE) : 1;

  typedef enum logic [1:0] {StIdle, StWaitChk, StResp} state_e;

  state_e         state_q;
  logic [7:0]     data_q;
  logic           seq_q;
  logic           exp_seq_q;
  logic           ack_valid_q;
  logic           ack_seq_q;
  logic           nak_q;
  logic [PW-1:0]  pulse_cnt_q;

  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;

  logic rx_valid, rx_seq, pop_req;
  logic fifo_empty, fifo_full;
  logic frame_good, new_seq, eval, push, pop;

  // Enable and spare input bits carry no function.
  logic unused_ok;
  assign unused_ok = ^{ena, uio_in[7:3]};

  assign rx_valid = uio_in[0];
  assign rx_seq   = uio_in[1];
  assign pop_req  = uio_in[2];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW + 1)'(DEPTH));

  // Frame evaluation; full is judged on pre-pop occupancy so a pop never rescues a push.
  always_comb begin
    frame_good = (ui_in == ~data_q);
    new_seq    = (seq_q == exp_seq_q);
    eval       = (state_q == StWaitChk) && rx_valid;
    push       = eval && frame_good && new_seq && !fifo_full;
    pop        = pop_req && !fifo_empty;
  end

  // Receive FSM with registered response pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= 8'h00;
      seq_q       <= 1'b0;
      exp_seq_q   <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_seq_q   <= 1'b0;
      nak_q       <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            data_q  <= ui_in;
            seq_q   <= rx_seq;
            state_q <= StWaitChk;
          end
        end
        StWaitChk: begin
          if (rx_valid) begin
            state_q     <= StResp;
            pulse_cnt_q <= PW'(ACK_PULSE - 1);
            // Duplicates are re-ACKed so a peer that lost our ACK can advance.
            if (frame_good && (!new_seq || !fifo_full)) begin
              ack_valid_q <= 1'b1;
              ack_seq_q   <= seq_q;
            end else begin
              nak_q <= 1'b1;
            end
            if (push) exp_seq_q <= ~exp_seq_q;
          end
        end
        StResp: begin
          if (pulse_cnt_q == '0) begin
            ack_valid_q <= 1'b0;
            ack_seq_q   <= 1'b0;
            nak_q       <= 1'b0;
            state_q     <= StIdle;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_q;
  end

  assign uo_out  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign uio_out = {fifo_full, fifo_empty, nak_q, ack_seq_q, ack_valid_q, 3'b000};
  assign uio_oe  = 8'b1111_1000;

endmodule
